// File: rtl/header_memory_mc.sv
// Header buffer: loads DEPTH words from the master, streams them to NUM_CH channels,
// then returns a found nonce. Define HDR_BCAST_EN to send the header once to all channels.
module header_memory_mc #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DEPTH       = 40,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned NONCE_WORDS = 2,
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             conwrite_i,
  inout  wire  [WIDTH-1:0] c2m_data_io,
  output logic             memwrite_o,
  output logic             valid_o,
  output logic             busy_o,
  inout  wire  [WIDTH-1:0] m2d_data_io,
  output logic             m2d_rwbit_o,
  output logic             m2d_strb_o,
  output logic [CH_W-1:0]  m2d_ch_o,
  output logic             m2d_bcast_o,
  input  logic             d2m_vld_i,
  input  logic             d2m_fail_i
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = (NONCE_WORDS > 1) ? $clog2(NONCE_WORDS) : 1;
  localparam int unsigned NonceW = WIDTH * NONCE_WORDS;

  localparam logic [PtrW-1:0] LastWord  = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] LastNonce = CntW'(NONCE_WORDS - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StDist, StWait, StResult} state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [NonceW-1:0] nonce_q, nonce_d;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic              mem_we;
  logic [PtrW-1:0]   mem_addr;

`ifndef HDR_BCAST_EN
  localparam logic [CH_W-1:0] LastCh = CH_W'(NUM_CH - 1);
  logic [CH_W-1:0] ch_q, ch_d;
`endif

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    nonce_d  = nonce_q;
    mem_we   = 1'b0;
    mem_addr = wr_ptr_q;
`ifndef HDR_BCAST_EN
    ch_d     = ch_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (conwrite_i) begin
          mem_we   = 1'b1;
          mem_addr = '0;
          wr_ptr_d = PtrW'(1);
          state_d  = StLoad;
        end
      end
      StLoad: begin
        if (conwrite_i) begin
          mem_we = 1'b1;
          if (wr_ptr_q == LastWord) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
`ifndef HDR_BCAST_EN
            ch_d     = '0;
`endif
            state_d  = StDist;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
      end
      StDist: begin
        if (rd_ptr_q == LastWord) begin
          rd_ptr_d = '0;
`ifdef HDR_BCAST_EN
          state_d  = StWait;
`else
          if (ch_q == LastCh) begin
            ch_d    = '0;
            state_d = StWait;
          end else begin
            ch_d = ch_q + 1'b1;
          end
`endif
          cnt_d   = '0;
          nonce_d = '0;
        end else begin
          rd_ptr_d = rd_ptr_q + 1'b1;
        end
      end
      StWait: begin
        // A failure drops any partially collected nonce, even alongside a valid word.
        if (d2m_fail_i) begin
          nonce_d = '0;
          cnt_d   = '0;
          state_d = StIdle;
        end else if (d2m_vld_i) begin
          nonce_d = (nonce_q << WIDTH) | NonceW'(m2d_data_io);
          if (cnt_q == LastNonce) begin
            cnt_d   = '0;
            state_d = StResult;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StResult: begin
        nonce_d = nonce_q << WIDTH;
        if (cnt_q == LastNonce) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      nonce_q  <= '0;
`ifndef HDR_BCAST_EN
      ch_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      nonce_q  <= nonce_d;
`ifndef HDR_BCAST_EN
      ch_q     <= ch_d;
`endif
    end
  end

  // Header storage needs no reset: every job overwrites all words before reading.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[mem_addr] <= c2m_data_io;
    end
  end

  assign busy_o      = (state_q == StDist) || (state_q == StWait) || (state_q == StResult);
  assign memwrite_o  = (state_q == StResult);
  assign valid_o     = (state_q == StResult);
  assign m2d_rwbit_o = (state_q == StDist);
  assign m2d_strb_o  = (state_q == StDist);

`ifdef HDR_BCAST_EN
  assign m2d_bcast_o = (state_q == StDist);
  assign m2d_ch_o    = '0;
`else
  assign m2d_bcast_o = 1'b0;
  assign m2d_ch_o    = ch_q;
`endif

  assign c2m_data_io = memwrite_o  ? nonce_q[NonceW-1 -: WIDTH] : {WIDTH{1'bz}};
  assign m2d_data_io = m2d_rwbit_o ? mem[rd_ptr_q]              : {WIDTH{1'bz}};

endmodule

// File: doc/header_memory_mc.md
# header_memory_mc

Parametrised header buffer for the miner datapath, sitting between the master controller and the distribution unit. Collects a block header of DEPTH words from the master over the shared controller bus, then streams it to NUM_CH hashing channels over the shared distribution bus. It waits for a result, and returns a found nonce to the master, driving valid_o. It generalises the single-channel memory block with configurable width, depth, channel count and nonce size, plus explicit bus-turnaround control.

## Interface
- WIDTH, 16: word width of both data buses
- DEPTH, 40: header words per job (≥2; 40×16 = 640-bit header)
- NUM_CH, 4: number of distribution channels (≥1)
- NONCE_WORDS, 2: words in a returned nonce (≥1)
- CH_W, $clog2(NUM_CH) (min 1): derived channel-index width

- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- conwrite_i  in  1  master write strobe; one header word per cycle high
- c2m_data_io  inout  WIDTH  controller bus; master drives when memwrite_o=0, block drives when memwrite_o=1
- memwrite_o  out  1  block is driving c2m_data_io with a result word
- valid_o  out  1  result word on c2m_data_io belongs to a valid mined nonce
- busy_o  out  1  no header input accepted
- m2d_data_io  inout  WIDTH  distribution bus; block drives when m2d_rwbit_o=1, else Z
- m2d_rwbit_o  out  1  distribution bus direction, 1 = memory drives
- m2d_strb_o  out  1  header word valid on m2d_data_io
- m2d_ch_o  out  CH_W  target channel of current header word
- m2d_bcast_o  out  1  word addressed to all channels (macro only, else tied 0)
- d2m_vld_i  in  1  distribution unit drives a nonce word on m2d_data_io
- d2m_fail_i  in  1  all channels exhausted, no nonce found

## Operation
- FSM: IDLE, LOAD, DIST, WAIT, RESULT.
- IDLE: busy_o=0. conwrite_i=1 writes c2m_data_io to mem[0], wr_ptr←1, go LOAD.
- LOAD: conwrite_i=1 writes mem[wr_ptr], wr_ptr++. Gaps (conwrite_i=0) hold state indefinitely. Write of word DEPTH-1 → DIST, wr_ptr←0.
- DIST: busy_o=1, m2d_rwbit_o=1, m2d_strb_o=1 every cycle. Order: channel 0 words 0..DEPTH-1, then channel 1, … NUM_CH-1. m2d_data_io=mem[rd_ptr], m2d_ch_o=ch. Lasts NUM_CH×DEPTH cycles, then → WAIT.
- WAIT: busy_o=1, m2d_rwbit_o=0, m2d_data_io=Z. Each d2m_vld_i cycle shifts m2d_data_io into the nonce register; the first word is most-significant. After NONCE_WORDS words → RESULT. d2m_fail_i → IDLE, discarding any partial nonce. fail has priority over a simultaneous vld.
- RESULT: busy_o=1, memwrite_o=1, valid_o=1, c2m_data_io=nonce word, MS first, one word per cycle for NONCE_WORDS cycles, then → IDLE.
- conwrite_i ignored in DIST, WAIT, RESULT. d2m_vld_i/d2m_fail_i ignored outside WAIT.
- Header contents persist after a job; the next job fully overwrites them.

## Timing
- All outputs are decoded from registered state only, with no input→output combinational path.
- Reset (rst_i=0): immediately, without a clock, state=IDLE, pointers/nonce=0. memwrite_o, valid_o, busy_o, m2d_rwbit_o, m2d_strb_o, m2d_bcast_o=0, m2d_ch_o=0, both buses Z. Reset mid-job aborts; the next load starts at word 0.
- busy_o rises in the cycle after the edge capturing word DEPTH-1. The first header word appears on m2d_data_io in that same cycle.
- The cycle after the last DIST word: m2d_rwbit_o=0 and m2d_data_io released. The distribution unit must not drive until the cycle after m2d_rwbit_o falls.
- Cycle after the edge capturing the last nonce word: memwrite_o=valid_o=1 for exactly NONCE_WORDS cycles. busy_o falls in the cycle after the last result word.
- Load-to-first-distribution latency: 1 cycle. Full job, excluding hashing: DEPTH + NUM_CH×DEPTH + NONCE_WORDS cycles minimum.

## Configuration
- HDR_BCAST_EN defined: DIST sends words 0..DEPTH-1 once (DEPTH cycles) with m2d_bcast_o=1 and m2d_ch_o=0.
- Undefined: per-channel serial distribution as above, m2d_bcast_o tied 0.

## Test plan
All with WIDTH=16, DEPTH=4, NUM_CH=2, NONCE_WORDS=2.
- Continuous load 0x1111,0x2222,0x3333,0x4444 → busy_o=1 next cycle. 8 strobes follow: ch0 1111..4444, then ch1 1111..4444, m2d_rwbit_o=1 throughout, then 0.
- Load same words with 2-cycle conwrite_i gaps between each → identical stored header and DIST sequence. busy_o stays 0 during gaps.
- In WAIT, d2m_vld_i with 0xDEAD then 0xBEEF → memwrite_o=valid_o=1 for 2 cycles, c2m_data_io=0xDEAD then 0xBEEF. busy_o=0 the following cycle.
- In WAIT after one vld word (0x1234), assert d2m_fail_i together with d2m_vld_i → IDLE, valid_o never asserts, busy_o=0 next cycle.
- Assert rst_i=0 during the 3rd DIST word → all outputs 0 and both buses Z with no clock edge. A new load of 0xA0..0xA3 distributes 0xA0 first.
- HDR_BCAST_EN build, load 0x1111..0x4444 → exactly 4 strobes with m2d_bcast_o=1, then WAIT.
